regfile_dump: RTL and testbench

Debug readout engine for the pipeline's 32x32 register file. On a start pulse it drives both read ports of `register_file` in pairs (ra1 = even, ra2 = odd address), captures `rd1`/`rd2`, and streams all registers out in ascending address order over a valid/ready interface. It also returns an XOR checksum of the snapshot. It sits beside the register file on the debug/test path and never drives the write port.

---
 rtl/regfile_dump.sv | 138 +++++++++++++
 tb/tb_regfile_dump.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump.sv
// regfile_dump: debug readout engine for the pipeline register file.
// It reads the file two registers at a time: even addresses on ra1 and odd
// addresses on ra2. The captured words are streamed in ascending address
// order over a valid/ready interface. An XOR checksum of the last completed
// dump is kept. The block never writes the register file.
module regfile_dump #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] ra1,
    output logic [ADDR_W-1:0] ra2,
    input  logic [DATA_W-1:0] rd1,
    input  logic [DATA_W-1:0] rd2,
    output logic [DATA_W-1:0] dout,
    output logic [ADDR_W-1:0] dout_idx,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              dout_last,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    localparam int PAIR_W = ADDR_W - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        EMIT0 = 2'd2,
        EMIT1 = 2'd3
    } state_t;

    state_t              state;
    logic [PAIR_W-1:0]   pair;
    // The odd word of the current pair. The even word is held directly in
    // dout from READ until it is accepted.
    logic [DATA_W-1:0]   buf1;
    // Running XOR of the words accepted so far in the current dump.
    logic [DATA_W-1:0]   acc;

    logic                accept;
    logic                last_pair;

    assign accept    = dout_valid & dout_ready;
    assign last_pair = &pair;

    // Both read addresses come straight from the pair flop, so they are
    // glitch-free and hold steady for the whole READ cycle.
    assign ra1 = {pair, 1'b0};
    assign ra2 = {pair, 1'b1};

    // Dump sequencer: READ captures a pair, EMIT0 and EMIT1 stream it out.
    // abort overrides every transition.
    // NOTE: every register here uses non-blocking assignment. All flops then
    // sample pre-edge values, so there are no ordering races between them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pair       <= '0;
            buf1       <= '0;
            acc        <= '0;
            dout       <= '0;
            dout_idx   <= '0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            checksum   <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                // Drop the stream at once and leave checksum alone. A word
                // accepted in this same cycle is already gone downstream.
                state      <= IDLE;
                pair       <= '0;
                dout_valid <= 1'b0;
                dout_last  <= 1'b0;
                busy       <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            state <= READ;
                            busy  <= 1'b1;
                            acc   <= '0;
                        end
                    end
                    READ: begin
                        dout       <= rd1;
                        buf1       <= rd2;
                        dout_idx   <= ra1;
                        dout_valid <= 1'b1;
                        dout_last  <= 1'b0;
                        state      <= EMIT0;
                    end
                    EMIT0: begin
                        if (dout_ready) begin
                            acc       <= acc ^ dout;
                            dout      <= buf1;
                            dout_idx  <= ra2;
                            dout_last <= last_pair;
                            state     <= EMIT1;
                        end
                    end
                    EMIT1: begin
                        if (dout_ready) begin
                            acc        <= acc ^ dout;
                            dout_valid <= 1'b0;
                            dout_last  <= 1'b0;
                            if (last_pair) begin
                                state    <= IDLE;
                                pair     <= '0;
                                busy     <= 1'b0;
                                done     <= 1'b1;
                                checksum <= acc ^ dout;
                            end else begin
                                pair  <= pair + PAIR_W'(1);
                                state <= READ;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // Unused in the datapath, but it documents the handshake qualifier.
    logic unused_accept;
    assign unused_accept = accept;

endmodule

// File: tb/tb_regfile_dump.sv
// Testbench for regfile_dump. A behavioural register file drives rd1/rd2.
// Stimulus pushes the expected words into a queue. A monitor pops and
// compares them on every accepted word, and also checks stall stability.
module tb_regfile_dump;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 32;

    typedef struct {
        logic [ADDR_W-1:0] idx;
        logic [DATA_W-1:0] data;
        logic              last;
    } exp_t;

    logic              clk_tb;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] ra1, ra2;
    logic [DATA_W-1:0] rd1, rd2;
    logic [DATA_W-1:0] dout;
    logic [ADDR_W-1:0] dout_idx;
    logic              dout_valid;
    logic              dout_ready = 1'b0;
    logic              dout_last;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] checksum;

    logic [DATA_W-1:0] regs [NREG];
    logic [DATA_W-1:0] exp_words [NREG];
    logic [DATA_W-1:0] exp_cks;
    logic [DATA_W-1:0] ref_cks;

    exp_t exp_q[$];
    exp_t mon_e;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc;
    int first_acc_cyc;
    int done_cyc;
    int done_cnt = 0;
    int acc_cnt = 0;
    logic bp_mode = 1'b0;

    logic              held = 1'b0;
    logic [DATA_W-1:0] h_dout;
    logic [ADDR_W-1:0] h_idx;
    logic              h_last;

    assign rd1 = regs[ra1];
    assign rd2 = regs[ra2];

    regfile_dump #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk_tb),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .ra1        (ra1),
        .ra2        (ra2),
        .rd1        (rd1),
        .rd2        (rd2),
        .dout       (dout),
        .dout_idx   (dout_idx),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last),
        .busy       (busy),
        .done       (done),
        .checksum   (checksum)
    );

    // 10 ns clock.
    initial begin
        clk_tb = 1'b0;
        forever #5 clk_tb = ~clk_tb;
    end

    // Cycle counter, used for the latency checks.
    always @(posedge clk_tb) cyc++;

    // Sink: tied ready, or random ready at about 30 % duty in backpressure mode.
    always @(posedge clk_tb) begin
        #1;
        dout_ready = bp_mode ? ($urandom_range(0, 9) < 3) : 1'b1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: checks words on acceptance, checks held outputs while stalled,
    // and counts done pulses.
    always @(negedge clk_tb) begin
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (held)
                check("stall_hold", {dout_valid, dout_last, dout_idx, dout},
                      {1'b1, h_last, h_idx, h_dout});
            if (dout_valid && dout_ready) begin
                acc_cnt++;
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_word: idx %0d data %0h accepted with none expected",
                             dout_idx, dout);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("word", {dout_last, dout_idx, dout}, {mon_e.last, mon_e.idx, mon_e.data});
                end
            end
            held   = dout_valid && !dout_ready;
            h_dout = dout;
            h_idx  = dout_idx;
            h_last = dout_last;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("busy_low_at_done", {63'd0, busy}, 64'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk_tb);
        #1;
    endtask

    task automatic preload();
        regs[0] = '0;
        for (int k = 1; k < NREG; k++) regs[k] = 32'hA500_0000 + k;
    endtask

    task automatic load_exp();
        for (int k = 0; k < NREG; k++) exp_words[k] = regs[k];
    endtask

    // Push the expected stream and pulse start. Called at #1 after an edge.
    task automatic start_dump();
        exp_t e;
        exp_cks = '0;
        for (int k = 0; k < NREG; k++) begin
            e.idx  = ADDR_W'(k);
            e.data = exp_words[k];
            e.last = (k == NREG - 1);
            exp_q.push_back(e);
            exp_cks ^= exp_words[k];
        end
        first_acc_cyc = -1;
        acc_cnt       = 0;
        start_cyc     = cyc;
        start         = 1'b1;
        tick();
        start         = 1'b0;
    endtask

    task automatic wait_idx(input int idx);
        for (int n = 0; n < 600; n++) begin
            if (dout_valid && dout_idx == ADDR_W'(idx)) return;
            tick();
        end
        check("wait_idx_timeout", 64'(idx), 64'hFFFF);
    endtask

    task automatic finish_dump(input string name);
        int prev;
        prev = done_cnt;
        for (int n = 0; n < 2000 && done_cnt == prev; n++) tick();
        check({name, "_done_seen"}, 64'(done_cnt - prev), 64'd1);
        check({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
        check({name, "_checksum"}, 64'(checksum), 64'(exp_cks));
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        preload();
        #12;
        check("reset_values", {ra1, ra2, dout, dout_idx, dout_valid, dout_last, busy, done},
              {5'd0, 5'd1, 32'd0, 5'd0, 4'b0000});
        check("reset_checksum", 64'(checksum), 64'd0);
        #10 rst_n = 1'b1;
        tick();

        // Full dump, ready tied high.
        ref_cks = '0;
        for (int k = 0; k < NREG; k++) ref_cks ^= regs[k];
        load_exp();
        start_dump();
        finish_dump("full");
        check("full_first_valid_cycle", 64'(first_acc_cyc - start_cyc), 64'd2);
        check("full_done_cycle", 64'(done_cyc - start_cyc), 64'd49);
        check("full_ref_checksum", 64'(checksum), 64'(ref_cks));
        check("full_word_count", 64'(acc_cnt), 64'd32);

        // Backpressure at about 30 % ready.
        bp_mode = 1'b1;
        tick();
        load_exp();
        start_dump();
        finish_dump("backpressure");
        check("bp_same_checksum", 64'(checksum), 64'(ref_cks));
        check("bp_word_count", 64'(acc_cnt), 64'd32);
        bp_mode = 1'b0;
        tick();
        tick();

        // Abort at acceptance of idx 9.
        begin
            int prev_done;
            prev_done = done_cnt;
            load_exp();
            start_dump();
            wait_idx(9);
            abort = 1'b1;
            tick();
            abort = 1'b0;
            check("abort_idle", {62'd0, busy, dout_valid}, 64'd0);
            check("abort_checksum_kept", 64'(checksum), 64'(ref_cks));
            check("abort_remaining", 64'(exp_q.size()), 64'd22);
            exp_q.delete();
            for (int n = 0; n < 4; n++) tick();
            check("abort_no_done", 64'(done_cnt - prev_done), 64'd0);
            load_exp();
            start_dump();
            finish_dump("after_abort");
        end

        // Writes during a dump. The write to reg 20 lands before its pair is
        // read, so it is seen. Reg 6 is written after its pair was captured,
        // so its old value streams.
        load_exp();
        exp_words[20] = 32'hDEAD_BEEF;
        start_dump();
        wait_idx(6);
        regs[20] = 32'hDEAD_BEEF;
        wait_idx(10);
        regs[6] = 32'h1234_5678;
        finish_dump("write_early");

        // Repeat with writes inside pair 10. Reg 21 is changed in EMIT0, after
        // capture, so its buffered old value streams.
        load_exp();
        start_dump();
        wait_idx(20);
        regs[21] = 32'h0BAD_F00D;
        wait_idx(21);
        regs[20] = 32'hDEAD_BEEF;
        finish_dump("write_emit");
        preload();
        tick();

        // start while busy is ignored.
        begin
            int prev_done;
            prev_done = done_cnt;
            load_exp();
            start_dump();
            wait_idx(5);
            start = 1'b1;
            tick();
            start = 1'b0;
            finish_dump("start_busy");
            for (int n = 0; n < 6; n++) tick();
            check("start_busy_single_done", 64'(done_cnt - prev_done), 64'd1);
            check("start_busy_word_count", 64'(acc_cnt), 64'd32);
        end

        // Asynchronous reset in EMIT0 at idx 14.
        begin
            int prev_done;
            prev_done = done_cnt;
            load_exp();
            start_dump();
            wait_idx(14);
            rst_n = 1'b0;
            #1;
            check("async_reset_values",
                  {ra1, ra2, dout, dout_idx, dout_valid, dout_last, busy, done},
                  {5'd0, 5'd1, 32'd0, 5'd0, 4'b0000});
            check("async_reset_checksum", 64'(checksum), 64'd0);
            #2 rst_n = 1'b1;
            exp_q.delete();
            for (int n = 0; n < 5; n++) tick();
            check("async_reset_no_done", 64'(done_cnt - prev_done), 64'd0);
            check("async_reset_idle", {62'd0, busy, dout_valid}, 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
